// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the scoreboarded register file.
//   RF_XLEN   default data width
//   RF_NREGS  default register count (power of two)
//   RF_NRD    default number of read ports
//   reg_addr_t  register address type for the default register count
package regfile_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;
    localparam int RF_AW    = $clog2(RF_NREGS);

    typedef logic [RF_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle between a register-file client and regfile_sb.
//   we/wa/wd                  write port
//   ra / rd / rbusy           NRD combinational read ports with busy flags
//   rsv_en/rsv_addr           destination reservation (producer issue)
//   rsv_conflict              reservation hit an already-busy register
//   busy_cnt                  number of reserved registers
// Modports: master (client side), slave (register file side).
interface regfile_sb_if import regfile_pkg::*; #(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
) ();
    localparam int AW = $clog2(NREGS);

    logic                          we;
    logic [AW-1:0]                 wa;
    logic [XLEN-1:0]               wd;
    logic [NRD-1:0][AW-1:0]        ra;
    logic [NRD-1:0][XLEN-1:0]      rd;
    logic [NRD-1:0]                rbusy;
    logic                          rsv_en;
    logic [AW-1:0]                 rsv_addr;
    logic                          rsv_conflict;
    logic [AW:0]                   busy_cnt;

    modport master (
        output we, wa, wd, ra, rsv_en, rsv_addr,
        input  rd, rbusy, rsv_conflict, busy_cnt
    );

    modport slave (
        input  we, wa, wd, ra, rsv_en, rsv_addr,
        output rd, rbusy, rsv_conflict, busy_cnt
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits plus a running count of busy bits.
//   clk, reset   clock, synchronous active-high reset
//   set_en/set_addr  reservation request (address 0 ignored)
//   clr_en/clr_addr  write-back clearing the busy bit (address 0 ignored)
//   busy         busy bit vector
//   busy_cnt     registered popcount of busy
//   conflict     combinational: reservation targets an already-busy register
module rf_scoreboard import regfile_pkg::*; #(
    parameter int NREGS = RF_NREGS,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt,
    output logic             conflict
);

    logic             set_v, clr_v, inc, dec;
    logic [NREGS-1:0] busy_nxt;

    assign set_v = set_en && (set_addr != '0);
    assign clr_v = clr_en && (clr_addr != '0);

    // busy[0] is never set, so a reservation of r0 cannot conflict.
    assign conflict = set_en && busy[set_addr];

    // Count tracks transitions, not requests: a set on an already-busy bit
    // adds nothing, and a clear overridden by a same-address set removes nothing.
    assign inc = set_v && !busy[set_addr];
    assign dec = clr_v && busy[clr_addr] && !(set_v && (set_addr == clr_addr));

    always_comb begin
        busy_nxt = busy;
        if (clr_v) busy_nxt[clr_addr] = 1'b0;
        if (set_v) busy_nxt[set_addr] = 1'b1;   // new producer wins
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            case ({inc, dec})
                2'b10:   busy_cnt <= busy_cnt + 1'b1;
                2'b01:   busy_cnt <= busy_cnt - 1'b1;
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NRD combinational read ports, one write
// port and a busy-bit scoreboard for pending producers. r0 reads as zero.
//   clk, reset   clock, synchronous active-high reset
//   bus          regfile_sb_if.slave (write, read, reservation, status)
// Build option: define RF_BYPASS_EN for write-through bypass of the
// in-flight write onto matching read ports (data and busy).
module regfile_sb import regfile_pkg::*; #(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
) (
    input  logic         clk,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    logic [NREGS-1:0][XLEN-1:0] mem;
    logic [NREGS-1:0]           busy;
    logic                       wr_v;

    assign wr_v = bus.we && (bus.wa != '0);

    always_ff @(posedge clk) begin
        if (reset)     mem          <= '0;
        else if (wr_v) mem[bus.wa]  <= bus.wd;
    end

    rf_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (bus.rsv_en),
        .set_addr (bus.rsv_addr),
        .clr_en   (bus.we),
        .clr_addr (bus.wa),
        .busy     (busy),
        .busy_cnt (bus.busy_cnt),
        .conflict (bus.rsv_conflict)
    );

`ifdef RF_BYPASS_EN
    // A same-cycle reservation of the written register keeps it busy, so the
    // bypass must not report it free.
    logic rsv_same;
    assign rsv_same = bus.rsv_en && (bus.rsv_addr == bus.wa);
`endif

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [XLEN-1:0] rd_st;
        logic            rb_st;

        assign rd_st = (bus.ra[i] == '0) ? '0 : mem[bus.ra[i]];
        assign rb_st = busy[bus.ra[i]];

`ifdef RF_BYPASS_EN
        logic hit;
        assign hit          = wr_v && (bus.wa == bus.ra[i]);
        assign bus.rd[i]    = hit ? bus.wd : rd_st;
        assign bus.rbusy[i] = (hit && !rsv_same) ? 1'b0 : rb_st;
`else
        assign bus.rd[i]    = rd_st;
        assign bus.rbusy[i] = rb_st;
`endif
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: data width in bits.
REQ-002 Parameter NREGS, default 32: register count; SHALL be a power of two, at least 2; AW = $clog2(NREGS).
REQ-003 Parameter NRD, default 2: number of combinational read ports, range 1-4.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 reset  input  1: reset is synchronous and active-high.
REQ-006 we  input  1: write enable.
REQ-007 wa  input  AW: write address.
REQ-008 wd  input  XLEN: write data.
REQ-009 ra  input  NRD x AW: read addresses, one per port.
REQ-010 rd  output  NRD x XLEN: read data, one per port.
REQ-011 rbusy  output  NRD: per port, the addressed register has a pending reservation.
REQ-012 rsv_en  input  1: reserve a destination register (producer issued).
REQ-013 rsv_addr  input  AW: register to reserve.
REQ-014 rsv_conflict  output  1: combinational; rsv_en high while busy[rsv_addr] is already set.
REQ-015 busy_cnt  output  AW+1: number of currently reserved registers.

Function
REQ-016 Register 0 SHALL read as zero on every port; writes and reservations to address 0 SHALL be ignored.
REQ-017 Reads SHALL be combinational: rd[i] = reg[ra[i]], and rbusy[i] = busy[ra[i]] (both subject to REQ-025).
REQ-018 On a rising edge with we=1 and wa!=0, reg[wa] SHALL take wd, and busy[wa] SHALL clear.
REQ-019 On a rising edge with rsv_en=1 and rsv_addr!=0, busy[rsv_addr] SHALL set.
REQ-020 Write and reservation to the same address in one cycle: data SHALL be written and busy SHALL end set, because the new producer wins.
REQ-021 Reservation of an already-busy register: busy SHALL stay set, busy_cnt SHALL be unchanged, and rsv_conflict SHALL be asserted for that cycle.
REQ-022 A write to a non-busy register SHALL update data only; busy_cnt SHALL be unchanged.
REQ-023 busy_cnt SHALL be a registered counter, updated in the same edge as the busy bits. It SHALL at all times equal the popcount of the busy bits, with range 0..NREGS-1.
REQ-024 Increment and decrement of busy_cnt in the same cycle (reserve of register X, write of busy register Y, X!=Y) SHALL leave the count unchanged.

Configuration
REQ-025 Macro RF_BYPASS_EN controls write-through bypass.
- Defined: when we=1, wa!=0 and wa==ra[i], rd[i] SHALL equal wd and rbusy[i] SHALL be 0 in the same cycle. The exception is rsv_en=1 with rsv_addr==wa, where rbusy[i] stays as stored.
- Undefined: rd and rbusy SHALL reflect stored state only, and new data SHALL be visible the cycle after the write.

Reset
REQ-026 While reset=1 at a rising edge, all registers SHALL become 0, all busy bits SHALL become 0 and busy_cnt SHALL become 0.
REQ-027 we and rsv_en SHALL be ignored during a reset edge, including any write or reservation already in progress.
REQ-028 After the reset edge, all rd SHALL read 0, all rbusy SHALL read 0 and rsv_conflict SHALL be 0 with rsv_en low.
REQ-029 There SHALL be no initial blocks for state; reset is the only initialisation.

Structure
REQ-030 A shared package regfile_pkg SHALL hold the default XLEN and NREGS constants and a typedef for the register address type.
REQ-031 The busy-bit array and busy_cnt SHALL live in one sub-module, rf_scoreboard; regfile_sb SHALL contain the data array, read muxes and bypass.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Reset: assert reset for 1 cycle after writing reg[5]=0xDEADBEEF, then read ra=5 -> rd=0, rbusy=0, busy_cnt=0.
- x0 protection: we=1, wa=0, wd=0xFFFFFFFF, plus rsv_en=1, rsv_addr=0 -> rd for ra=0 stays 0, busy_cnt stays 0.
- Scoreboard: reserve r3 -> next cycle rbusy=1 for ra=3 and busy_cnt=1. Write r3=0x12 -> next cycle rbusy=0, rd=0x12, busy_cnt=0.
- Same-cycle collisions:
  - Reserve r7 and write r7=0x55 in one cycle -> rd=0x55, rbusy=1, busy_cnt=1.
  - Reserve r4 while writing busy r7 -> busy_cnt unchanged.
  - Re-reserve r4 -> rsv_conflict=1 and busy_cnt unchanged.
- Bypass: r9 busy holding 0x1, write wd=0xA5A5 to r9 with ra[0]=9 in the same cycle:
  - With RF_BYPASS_EN: rd[0]=0xA5A5 and rbusy[0]=0 in that cycle.
  - Without RF_BYPASS_EN: rd[0]=0x1 and rbusy[0]=1 in that cycle.
  - Both builds: 0xA5A5 on the next cycle.
- Parameters: repeat the scoreboard scenario with XLEN=64, NREGS=16, NRD=3. Write r15 = 64'h0123_4567_89AB_CDEF -> all three ports read the full value, and busy_cnt width is 5.
